// File: rtl/digit_serial_add_sub.sv
// Digit-serial WIDTH-bit two's-complement add/sub, DIGIT bits per cycle; N=WIDTH/DIGIT cycles accept-to-out_valid.
// One transaction in flight: in_ready only in IDLE, result held in DONE until out_ready.
module digit_serial_add_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow,
  output logic             Zero
);

  localparam int N    = WIDTH / DIGIT;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cy_q, cy_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   dig_sum;
  logic             msb_cin;
  logic             last_dig;
  logic [WIDTH-1:0] sum_upd;

  // One DIGIT-bit ripple per cycle; b_q already holds B inverted for subtract.
  always_comb begin
    a_dig    = a_q[int'(idx_q)*DIGIT +: DIGIT];
    b_dig    = b_q[int'(idx_q)*DIGIT +: DIGIT];
    dig_sum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, cy_q};
    // Carry into the top bit of this digit, recovered from its sum bit.
    msb_cin  = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dig_sum[DIGIT-1];
    last_dig = (idx_q == IDXW'(N - 1));
    sum_upd  = sum_q;
    sum_upd[int'(idx_q)*DIGIT +: DIGIT] = dig_sum[DIGIT-1:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B ^ {WIDTH{Sel}};
          cy_d    = Sel;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d = sum_upd;
        cy_d  = dig_sum[DIGIT];
        idx_d = IDXW'(idx_q + 1'b1);
        if (last_dig) begin
          idx_d   = '0;
          carry_d = dig_sum[DIGIT];
          ovf_d   = msb_cin ^ dig_sum[DIGIT];
          zero_d  = (sum_upd == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Sum       = sum_q;
  assign Carry     = carry_q;
  assign Overflow  = ovf_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Scoreboard bench: directed 16/4 vectors plus random sweeps on (4,1), (8,8), (32,4).
module tb_digit_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, tag, act, exp);
    end
  endtask

  // ---------------- main instance: WIDTH=16, DIGIT=4 ----------------
  logic        rst, in_valid, in_ready, Sel, out_valid, out_ready;
  logic [15:0] A, B, Sum;
  logic        Carry, Overflow, Zero;

  digit_serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Sel(Sel), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Carry(Carry), .Overflow(Overflow), .Zero(Zero)
  );

  typedef struct {
    logic [15:0] s;
    logic        c, v, z;
    int          acc;
    int          tag;
  } exp_t;
  exp_t mq[$];
  logic prev_ov = 1'b0;

  // Latency checked on the rising edge of out_valid; values checked when taken.
  always @(negedge clk) begin
    if (out_valid && !prev_ov) begin
      if (mq.size() == 0) chk("lat_noexp", 0, 64'd1, 64'd0);
      else chk("latency16", mq[0].tag, 64'(cyc - mq[0].acc), 64'd4);
    end
    if (out_valid && out_ready) begin
      if (mq.size() == 0) chk("pop_noexp", 0, 64'd1, 64'd0);
      else begin
        exp_t e;
        e = mq.pop_front();
        chk("sum16",  e.tag, 64'(Sum),      64'(e.s));
        chk("carry16", e.tag, 64'(Carry),   64'(e.c));
        chk("ovf16",  e.tag, 64'(Overflow), 64'(e.v));
        chk("zero16", e.tag, 64'(Zero),     64'(e.z));
      end
    end
    prev_ov <= out_valid;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s, input bit push,
                      input logic [15:0] es, input logic ec, input logic ev, input logic ez, input int tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("send_timeout", tag, 64'd0, 64'd1);
    A = a; B = b; Sel = s; in_valid = 1'b1;
    if (push) mq.push_back('{s: es, c: ec, v: ev, z: ez, acc: cyc + 1, tag: tag});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int tag);
    int n;
    n = 0;
    while (!(in_ready && mq.size() == 0) && n < 50) begin
      tick();
      n++;
    end
    if (!(in_ready && mq.size() == 0)) chk("idle_timeout", tag, 64'd0, 64'd1);
  endtask

  // ---------------- parameter sweep instances ----------------
  bit sw_done [3];

  for (genvar g = 0; g < 3; g++) begin : gen_sw
    localparam int SW = (g == 0) ? 4 : (g == 1) ? 8 : 32;
    localparam int SD = (g == 0) ? 1 : (g == 1) ? 8 : 4;
    localparam int SN = SW / SD;

    logic          s_rst, s_iv, s_ir, s_sel, s_ov;
    logic          s_or;
    logic [SW-1:0] s_a, s_b, s_sum;
    logic          s_c, s_v, s_z;

    digit_serial_add_sub #(.WIDTH(SW), .DIGIT(SD)) u_sw (
      .clk(clk), .rst(s_rst), .in_valid(s_iv), .in_ready(s_ir),
      .A(s_a), .B(s_b), .Sel(s_sel), .out_valid(s_ov), .out_ready(s_or),
      .Sum(s_sum), .Carry(s_c), .Overflow(s_v), .Zero(s_z)
    );

    logic [SW-1:0] q_sum[$];
    logic [2:0]    q_cvz[$];
    int            q_acc[$];

    always @(negedge clk) begin
      if (!s_rst && s_ov) begin
        if (q_sum.size() == 0) chk("sw_noexp", g, 64'd1, 64'd0);
        else begin
          logic [SW-1:0] es;
          logic [2:0]    ef;
          int            ea;
          es = q_sum.pop_front();
          ef = q_cvz.pop_front();
          ea = q_acc.pop_front();
          chk("sw_sum",   g, 64'(s_sum), 64'(es));
          chk("sw_carry", g, 64'(s_c),   64'(ef[2]));
          chk("sw_ovf",   g, 64'(s_v),   64'(ef[1]));
          chk("sw_zero",  g, 64'(s_z),   64'(ef[0]));
          chk("sw_lat",   g, 64'(cyc - ea), 64'(SN));
        end
      end
    end

    initial begin
      logic [SW-1:0] ra, rb, bx;
      logic          rs;
      logic [SW:0]   full;
      logic          ovf;
      int            n;
      s_rst = 1'b1; s_iv = 1'b0; s_or = 1'b1; s_a = '0; s_b = '0; s_sel = 1'b0;
      repeat (2) @(posedge clk);
      #1 s_rst = 1'b0;
      for (int t = 0; t < 12; t++) begin
        ra = SW'({$urandom, $urandom});
        rb = SW'({$urandom, $urandom});
        rs = 1'($urandom_range(0, 1));
        if (t == 0) begin ra = {1'b0, {(SW-1){1'b1}}}; rb = SW'(1); rs = 1'b0; end
        if (t == 1) begin ra = {1'b1, {(SW-1){1'b0}}}; rb = SW'(1); rs = 1'b1; end
        bx   = rb ^ {SW{rs}};
        full = {1'b0, ra} + {1'b0, bx} + (SW+1)'(rs);
        ovf  = (ra[SW-1] == bx[SW-1]) && (full[SW-1] != ra[SW-1]);
        n = 0;
        while (!s_ir && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        if (!s_ir) chk("sw_send_timeout", g, 64'd0, 64'd1);
        s_a = ra; s_b = rb; s_sel = rs; s_iv = 1'b1;
        q_sum.push_back(full[SW-1:0]);
        q_cvz.push_back({full[SW], ovf, full[SW-1:0] == '0});
        q_acc.push_back(cyc + 1);
        @(posedge clk); #1;
        s_iv = 1'b0;
      end
      repeat (SN + 4) @(posedge clk);
      #1 chk("sw_drain", g, 64'(q_sum.size()), 64'd0);
      sw_done[g] = 1'b1;
    end
  end

  // ---------------- directed stimulus on the 16/4 instance ----------------
  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; Sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  0, 64'(in_ready),  64'd1);
    chk("rst_out_valid", 0, 64'(out_valid), 64'd0);
    chk("rst_sum",       0, 64'(Sum),       64'd0);
    chk("rst_cvz",       0, 64'({Carry, Overflow, Zero}), 64'd0);
    rst = 1'b0;
    tick();

    send(16'h1234, 16'h0FFF, 1'b0, 1, 16'h2233, 1'b0, 1'b0, 1'b0, 1); wait_idle(1);
    send(16'h0005, 16'h0007, 1'b1, 1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 2); wait_idle(2);
    send(16'h1234, 16'h1234, 1'b1, 1, 16'h0000, 1'b1, 1'b0, 1'b1, 3); wait_idle(3);
    send(16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 1'b0, 1'b1, 1'b0, 4); wait_idle(4);
    send(16'h8000, 16'h0001, 1'b1, 1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 5); wait_idle(5);
    send(16'hFFFF, 16'h0001, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b1, 6); wait_idle(6);
    send(16'h8000, 16'h8000, 1'b0, 1, 16'h0000, 1'b1, 1'b1, 1'b1, 7); wait_idle(7);
    send(16'h0000, 16'h0001, 1'b1, 1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8);
    // Back-to-back: next accept waits for in_ready, no idle gap inserted here.
    send(16'hA5A5, 16'h5A5A, 1'b0, 1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 9); wait_idle(9);

    // Backpressure: hold result in DONE for 5 cycles, poke in_valid meanwhile.
    out_ready = 1'b0;
    send(16'h00FF, 16'h0F01, 1'b0, 1, 16'h1000, 1'b0, 1'b0, 1'b0, 10);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("bp_reached_done", 10, 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready",  i, 64'(in_ready),  64'd0);
      chk("bp_out_valid", i, 64'(out_valid), 64'd1);
      chk("bp_sum",       i, 64'(Sum),       64'h1000);
      chk("bp_cvz",       i, 64'({Carry, Overflow, Zero}), 64'd0);
      if (i == 1) begin A = 16'h1111; B = 16'h1111; Sel = 1'b0; in_valid = 1'b1; end
      if (i == 2) in_valid = 1'b0;
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_ready", 10, 64'(in_ready),  64'd1);
    chk("bp_release_ov",    10, 64'(out_valid), 64'd0);
    chk("bp_drained",       10, 64'(mq.size()), 64'd0);
    tick();
    chk("bp_ignored_pulse", 10, 64'(in_ready), 64'd1);

    // Reset on the second RUN cycle aborts the transaction.
    send(16'h4321, 16'h1111, 1'b0, 0, 16'h0, 1'b0, 1'b0, 1'b0, 11);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready",  11, 64'(in_ready),  64'd1);
    chk("mid_rst_out_valid", 11, 64'(out_valid), 64'd0);
    chk("mid_rst_sum",       11, 64'(Sum),       64'd0);
    chk("mid_rst_carry",     11, 64'(Carry),     64'd0);
    send(16'h0001, 16'h0001, 1'b0, 1, 16'h0002, 1'b0, 1'b0, 1'b0, 12); wait_idle(12);

    n = 0;
    while (!(sw_done[0] && sw_done[1] && sw_done[2]) && n < 2000) begin tick(); n++; end
    if (!(sw_done[0] && sw_done[1] && sw_done[2])) chk("sweep_timeout", 0, 64'd0, 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/digit_serial_add_sub.md
# digit_serial_add_sub

Parametrised WIDTH-bit two's-complement adder/subtractor that processes DIGIT bits per clock, trading latency for ripple depth. Accepts one operand pair per transaction over a valid/ready handshake, computes A+B or A−B from LSB digit to MSB digit with a registered inter-digit carry, and holds the result, carry and flags until the consumer takes them. It is the multi-width, multi-cycle successor to the team's fixed 4-bit ripple adder/subtractor, and it sits in datapaths where WIDTH is too wide for a single-cycle ripple at target clock.

## Interface
- WIDTH, 16, operand/result width in bits; must be ≥2 and a multiple of DIGIT
- DIGIT, 4, bits processed per RUN cycle; 1 ≤ DIGIT ≤ WIDTH; N = WIDTH/DIGIT
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair on A/B/Sel is valid
- in_ready  out  1  block can accept; high only in IDLE
- A  in  WIDTH  first operand
- B  in  WIDTH  second operand
- Sel  in  1  0 = A+B, 1 = A−B (B inverted, carry-in 1)
- out_valid  out  1  result outputs valid; high only in DONE
- out_ready  in  1  consumer takes result
- Sum  out  WIDTH  result, modulo 2^WIDTH
- Carry  out  1  carry out of MSB; for subtract, 1 = no borrow (A ≥ B unsigned)
- Overflow  out  1  signed overflow (carry into MSB XOR carry out of MSB)
- Zero  out  1  Sum == 0

## Operation
- States: IDLE, RUN, DONE. Reset value IDLE.
- IDLE: in_ready=1. On in_valid=1: latch A, B^{WIDTH{Sel}}, Sel; carry register ← Sel; digit index ← 0; → RUN.
- RUN: each edge adds digit k of A and inverted-B plus carry register; writes DIGIT sum bits into Sum[k*DIGIT +: DIGIT]; updates carry register; k increments. Inputs A/B/Sel/in_valid ignored.
- After the edge that processes digit N−1: Carry ← final carry, Overflow ← carry-in XOR carry-out of bit WIDTH−1, Zero ← (final Sum == 0); → DONE.
- DONE: out_valid=1; Sum, Carry, Overflow, Zero stable. On out_ready=1 → IDLE. No new accept in the same cycle (in_ready=0 in DONE).
- Sum, Carry, Overflow, Zero keep their last values in IDLE until the next transaction completes; they are valid only while out_valid=1. Sum changes digit by digit during RUN.
- Arithmetic: Sum = (A + (B^{WIDTH{Sel}}) + Sel) mod 2^WIDTH; bit-exact with a single-cycle WIDTH-bit ripple adder/subtractor.
- Reset: rst=1 at any edge, including mid-RUN or in DONE, forces IDLE, aborts the transaction, and clears Sum, Carry, Overflow, Zero, carry register and digit index to 0. rst has priority over every handshake.

## Timing
- Reset values: in_ready=1, out_valid=0, Sum=0, Carry=0, Overflow=0, Zero=0.
- Accept at edge t (in_valid & in_ready). RUN occupies edges t+1 … t+N. out_valid rises after edge t+N, so latency is N cycles from accept to out_valid.
- Example: WIDTH=16, DIGIT=4 gives latency 4. DIGIT=WIDTH gives latency 1.
- DONE→IDLE on edge where out_ready=1. in_ready reasserts the next cycle.
- Maximum throughput is one result per N+2 cycles.
- in_ready and out_valid are decoded from the state register only, with no combinational path from in_valid or out_ready.
- Critical path: one DIGIT-bit ripple plus the carry register.

## Test plan
- WIDTH=16, DIGIT=4, Sel=0: A=0x1234, B=0x0FFF. Expect Sum=0x2233, Carry=0, Overflow=0, Zero=0; out_valid exactly 4 cycles after accept.
- Sel=1 cases:
  - A=0x0005, B=0x0007: expect Sum=0xFFFE, Carry=0, Overflow=0.
  - A=0x1234, B=0x1234: expect Sum=0x0000, Carry=1, Zero=1.
- Signed overflow:
  - 0x7FFF+0x0001: expect Sum=0x8000, Overflow=1, Carry=0.
  - 0x8000−0x0001: expect Sum=0x7FFF, Overflow=1, Carry=1.
  - 0xFFFF+0x0001: expect Sum=0x0000, Carry=1, Overflow=0, Zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Outputs stay stable, in_ready=0, and an in_valid pulse with new operands is ignored. Then out_ready=1 gives IDLE the next cycle.
- Reset mid-RUN: assert rst on the 2nd RUN cycle. Next cycle: in_ready=1, out_valid=0, Sum=0, Carry=0. A fresh 0x0001+0x0001 then yields 0x0002 with latency 4.
- Parameter sweep (WIDTH,DIGIT) ∈ {(4,1),(8,8),(32,4)}: random operands and Sel are checked against a reference model of (A ± B) mod 2^WIDTH, carry and overflow. Latency must equal WIDTH/DIGIT in every run.
